rf_scoreboard: RTL
==================

Name: rf_scoreboard

Overview:
- Read-after-write hazard controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Tracks how many in-flight instructions target each GPR and stalls ID while any source operand it needs is still pending.
- Entries are marked at ID issue and cleared when the WB stage drives its register-file write.
- Sits beside ID and consumes the WB write-back fields (rf_we, rf_waddr) as the retire event.

Parameters:
- NUM_REGS, 32, number of architectural GPRs (r0 is hardwired zero, never tracked)
- CNT_W, 2, width of each per-register pending counter
- MAX_INFLIGHT, 3, saturation limit per register; must be <= 2^CNT_W-1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_issue_valid  in  1  ID instruction leaves ID this cycle (ID valid && ready_go && EX allow_in)
- id_issue_we  in  1  issuing instruction writes a GPR
- id_issue_dest  in  5  destination register of issuing instruction
- id_rj  in  5  source register rj of instruction currently in ID
- id_rk  in  5  source register rk
- id_rd  in  5  rd used as source (store data, branch compare)
- id_src_use  in  3  {rd_used, rk_used, rj_used}
- id_inst_valid  in  1  ID holds a valid instruction
- wb_retire_valid  in  1  WB valid this cycle
- wb_retire_we  in  1  WB rf_we
- wb_retire_dest  in  5  WB rf_waddr
- id_stall  out  1  ID must hold; gates ID ready_go
- busy_mask  out  NUM_REGS  bit i set when counter[i] != 0 (bit 0 always 0)

Behaviour:
- State: one CNT_W-bit counter per register 1..31; register 0 is never incremented.
- Reset: all counters 0; id_stall=0; busy_mask=0. Reset mid-operation clears every counter regardless of in-flight instructions; the pipeline is reset together with it.
- inc[i] = id_issue_valid && id_issue_we && id_issue_dest==i && i!=0.
- dec[i] = wb_retire_valid && wb_retire_we && wb_retire_dest==i && i!=0.
- Next-state update, on the clock edge:
  - inc only: +1
  - dec only: -1
  - both: unchanged (same-cycle issue and retire of the same register)
  - neither: hold
- Hazard conditions:
  - src_hit = any used source s (nonzero) with counter[s] != 0.
  - dest_full = id_issue_we-candidate dest counter == MAX_INFLIGHT. The dest is presented on id_issue_dest while ID holds the instruction.
  - id_stall = id_inst_valid && (src_hit || dest_full). Purely combinational from current counters; no same-cycle WB bypass, because the RF write lands at the edge.
- Latency: a retire at cycle N clears the stall at cycle N+1. Issue at N makes a dependent instruction stall from N+1.
- Sources equal to 0 never stall. An unused source (its id_src_use bit clear) never stalls.
- Error cases, both simulation-only assertion failures:
  - dec on a zero counter: the counter holds at 0.
  - inc at MAX_INFLIGHT: must not occur, because dest_full stalls it; the counter saturates.
- busy_mask is registered-equivalent: a combinational decode of the counters, valid the cycle after the update.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- When defined:
  - Adds output stall_cycles[31:0], counting cycles with id_stall=1, reset to 0, wrapping at 2^32.
  - Adds output raw_hazards[31:0], counting rising edges of src_hit && id_inst_valid.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared header (mycpu_top.h) holds:
  - the constants NUM_REGS, CNT_W, MAX_INFLIGHT;
  - the macro SB_DEST_W=5;
  - the bus-field width defines for the issue and retire tuples.
- One sub-module, sb_counter: a single saturating up/down counter with inc, dec, count, nonzero. It is instantiated 31 times via generate.

Test Plan:
- Reset check: after reset, busy_mask=0 and id_stall=0. An ID with rj=5 used, valid -> no stall.
- Basic RAW:
  - Issue dest=5 at cycle 0.
  - Cycles 1..k: ID rj=5 -> id_stall=1.
  - Retire dest=5 at cycle 3 -> id_stall=0 at cycle 4; counter[5]=0.
- r0 immunity: issue dest=0, then ID rj=0,rk=0 -> never stall; busy_mask[0]=0.
- Simultaneous: counter[7]=1; same cycle issue dest=7 and retire dest=7 -> counter[7] stays 1, busy_mask[7]=1.
- Saturation: three issues dest=9 without retire -> counter=3. The 4th ID with dest=9 -> id_stall=1 via dest_full until one retire.
- Unused source / stats:
  - rk=12 busy with rk_used=0 -> no stall.
  - With SCOREBOARD_STATS_EN, 4 stall cycles -> stall_cycles=4, raw_hazards=1.

Source files
------------

// File: rtl/rf_scoreboard_pkg.sv
// Shared constants for the RAW-hazard scoreboard: register-file geometry,
// per-register counter sizing and the issue/retire tuple widths.
package rf_scoreboard_pkg;

  localparam int NUM_REGS     = 32;
  localparam int CNT_W        = 2;
  localparam int MAX_INFLIGHT = 3;   // must stay <= 2**CNT_W-1
  localparam int SB_DEST_W    = 5;

  // {valid, we, dest} tuples carried by the issue and retire buses
  localparam int SB_ISSUE_W  = 2 + SB_DEST_W;
  localparam int SB_RETIRE_W = 2 + SB_DEST_W;

  typedef logic [SB_DEST_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]     sb_cnt_t;

endpackage

// File: rtl/rf_scoreboard_if.sv
// ID-issue / WB-retire bundle between the pipeline and the scoreboard.
// Stats outputs exist only when SCOREBOARD_STATS_EN is defined.
interface rf_scoreboard_if;
  import rf_scoreboard_pkg::*;

  logic                id_issue_valid;
  logic                id_issue_we;
  reg_idx_t            id_issue_dest;
  reg_idx_t            id_rj;
  reg_idx_t            id_rk;
  reg_idx_t            id_rd;
  logic [2:0]          id_src_use;     // {rd_used, rk_used, rj_used}
  logic                id_inst_valid;
  logic                wb_retire_valid;
  logic                wb_retire_we;
  reg_idx_t            wb_retire_dest;
  logic                id_stall;
  logic [NUM_REGS-1:0] busy_mask;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]         stall_cycles;
  logic [31:0]         raw_hazards;
`endif

  modport master (
    output id_issue_valid, id_issue_we, id_issue_dest,
    output id_rj, id_rk, id_rd, id_src_use, id_inst_valid,
    output wb_retire_valid, wb_retire_we, wb_retire_dest,
    input  id_stall, busy_mask
`ifdef SCOREBOARD_STATS_EN
    , input stall_cycles, raw_hazards
`endif
  );

  modport slave (
    input  id_issue_valid, id_issue_we, id_issue_dest,
    input  id_rj, id_rk, id_rd, id_src_use, id_inst_valid,
    input  wb_retire_valid, wb_retire_we, wb_retire_dest,
    output id_stall, busy_mask
`ifdef SCOREBOARD_STATS_EN
    , output stall_cycles, raw_hazards
`endif
  );

endinterface

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter for one GPR; simultaneous inc and
// dec cancel. Over/underflow attempts hold the value and fire an assertion.
module sb_counter #(
  parameter int CNT_W     = 2,
  parameter int MAX_COUNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  // NOTE: state registers use non-blocking assignments so every counter
  // samples the pre-edge value of its neighbours and of the hazard logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({inc, dec})
        2'b10:   if (count != MAX_C) count <= count + 1'b1;
        2'b01:   if (count != '0)    count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign nonzero = (count != '0);

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(dec && !inc && count == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(inc && !dec && count == MAX_C));

endmodule

// File: rtl/rf_scoreboard.sv
// RAW-hazard scoreboard beside ID: per-GPR pending-write counters, ID stall.
// Optional stall statistics are built when SCOREBOARD_STATS_EN is defined.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  rf_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            nonzero;
  logic                           src_hit;
  logic                           dest_full;

  // r0 is hardwired zero and never tracked
  assign cnt[0]     = '0;
  assign nonzero[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    logic inc;
    logic dec;

    assign inc = sb.id_issue_valid  && sb.id_issue_we  && (sb.id_issue_dest  == SB_DEST_W'(i));
    assign dec = sb.wb_retire_valid && sb.wb_retire_we && (sb.wb_retire_dest == SB_DEST_W'(i));

    sb_counter #(
      .CNT_W     (CNT_W),
      .MAX_COUNT (MAX_INFLIGHT)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc),
      .dec     (dec),
      .count   (cnt[i]),
      .nonzero (nonzero[i])
    );
  end

  // NOTE: src_hit gets its default before any condition so no latch is inferred.
  always_comb begin
    src_hit = 1'b0;
    if (sb.id_src_use[0] && sb.id_rj != '0 && nonzero[sb.id_rj]) src_hit = 1'b1;
    if (sb.id_src_use[1] && sb.id_rk != '0 && nonzero[sb.id_rk]) src_hit = 1'b1;
    if (sb.id_src_use[2] && sb.id_rd != '0 && nonzero[sb.id_rd]) src_hit = 1'b1;
  end

  // A fourth in-flight writer of one register would overflow its counter
  assign dest_full = sb.id_issue_we && (sb.id_issue_dest != '0) &&
                     (cnt[sb.id_issue_dest] == CNT_W'(MAX_INFLIGHT));

  // No WB bypass: the register-file write only lands at the clock edge
  assign sb.id_stall  = sb.id_inst_valid && (src_hit || dest_full);
  assign sb.busy_mask = nonzero;

`ifdef SCOREBOARD_STATS_EN
  logic        raw_now;
  logic        raw_q;
  logic [31:0] stall_cnt;
  logic [31:0] raw_cnt;

  assign raw_now = src_hit && sb.id_inst_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      raw_cnt   <= '0;
      raw_q     <= 1'b0;
    end else begin
      raw_q <= raw_now;
      if (sb.id_stall)       stall_cnt <= stall_cnt + 32'd1;
      if (raw_now && !raw_q) raw_cnt   <= raw_cnt + 32'd1;
    end
  end

  assign sb.stall_cycles = stall_cnt;
  assign sb.raw_hazards  = raw_cnt;
`endif

endmodule
